ram_resp: RTL and testbench

//  Main-memory responder for the 16-bit SAP datapath; the target of the address

---
 rtl/ram_resp_if.sv | 24 ++
 rtl/ram_resp.sv | 137 +++++++++++++
 tb/tb_ram_resp.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_resp_if.sv
// Request/response bundle between the control sequencer (master) and the
// main-memory responder (slave) of the 16-bit SAP datapath.
interface ram_resp_if #(
    parameter int DATA_W = 16
);
    logic [15:0]       mar_addr;
    logic              ram_read;
    logic              ram_write;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] ram_out;
    logic              ram_ready;
    logic              busy;
    logic              addr_err;

    modport master (
        output mar_addr, ram_read, ram_write, bus,
        input  ram_out, ram_ready, busy, addr_err
    );

    modport slave (
        input  mar_addr, ram_read, ram_write, bus,
        output ram_out, ram_ready, busy, addr_err
    );
endinterface

// File: rtl/ram_resp.sv
// Main-memory responder: accepts one read or write from IDLE, waits WAIT_STATES
// cycles, commits the access and pulses ram_ready for one cycle.
module ram_resp #(
    parameter int DATA_W      = 16,
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic      clk,
    input  logic      rst,
    ram_resp_if.slave mem
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         DEPTH    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [15:0]       r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_wr;
    logic [DATA_W-1:0] r_out;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req_one;
    logic              w_req_both;
    logic              w_enter_done;
    logic [15:0]       w_c_addr;
    logic [DATA_W-1:0] w_c_data;
    logic              w_c_wr;
    logic              w_c_oor;
    logic              w_commit_wr;
    logic              w_commit_rd;

    // The access seen on the edge entering DONE comes straight from the inputs
    // when there are no wait states, otherwise from the capture registers.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_req_one    = mem.ram_read ^ mem.ram_write;
        w_req_both   = mem.ram_read & mem.ram_write;
        w_enter_done = 1'b0;
        w_c_addr     = r_addr;
        w_c_data     = r_data;
        w_c_wr       = r_wr;
        case (r_state)
            S_IDLE: begin
                if (WAIT_STATES == 0 && w_req_one) begin
                    w_enter_done = 1'b1;
                    w_c_addr     = mem.mar_addr;
                    w_c_data     = mem.bus;
                    w_c_wr       = mem.ram_write;
                end
            end
            S_WAIT:  w_enter_done = (r_cnt == 4'd0);
            default: w_enter_done = 1'b0;
        endcase
        w_c_oor     = (w_c_addr >> ADDR_BITS) != 16'd0;
        w_commit_wr = w_enter_done & w_c_wr & ~w_c_oor;
        w_commit_rd = w_enter_done & ~w_c_wr;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 16'd0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_both) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_req_one) begin
                        r_addr <= mem.mar_addr;
                        r_data <= mem.bus;
                        r_wr   <= mem.ram_write;
                        r_cnt  <= CNT_LOAD;
                        r_busy <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b1;
                            r_err   <= w_c_oor;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        r_ready <= 1'b1;
                        r_err   <= w_c_oor;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_commit_rd) begin
                r_out <= w_c_oor ? '0 : r_mem[w_c_addr[ADDR_BITS-1:0]];
            end
        end
    end

    // NOTE: the array has no reset; contents survive reset, and gating with rst keeps an aborted write from landing.
    always_ff @(posedge clk) begin
        if (w_commit_wr && !rst) begin
            r_mem[w_c_addr[ADDR_BITS-1:0]] <= w_c_data;
        end
    end

    assign mem.ram_out   = r_out;
    assign mem.ram_ready = r_ready;
    assign mem.busy      = r_busy;
    assign mem.addr_err  = r_err;
endmodule

// File: tb/tb_ram_resp.sv
// Bench for ram_resp: scoreboard-checked randomized traffic on a WAIT_STATES=1
// instance, plus latency/busy checks on WAIT_STATES=0 and 3 instances.
module tb_ram_resp;
    localparam int W_MAIN = 1;

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_ILL} op_t;
    typedef struct {
        op_t         op;
        logic [15:0] addr;
        logic [15:0] data;
        int          ready_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t        sb[$];
    logic [15:0] mm [256];
    bit          mk [256];
    logic [15:0] mo = 16'd0;
    bit          mo_known = 1'b1;

    logic [15:0] x_addr;
    logic [15:0] x_data;
    logic        x0_rd, x0_wr, x3_rd, x3_wr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_resp_if #(.DATA_W(16)) m_if ();
    ram_resp_if #(.DATA_W(16)) a0_if ();
    ram_resp_if #(.DATA_W(16)) a3_if ();

    ram_resp #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(W_MAIN)) dut (.clk(clk), .rst(rst), .mem(m_if));
    ram_resp #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(0))      u_w0 (.clk(clk), .rst(rst), .mem(a0_if));
    ram_resp #(.DATA_W(16), .ADDR_BITS(8), .WAIT_STATES(3))      u_w3 (.clk(clk), .rst(rst), .mem(a3_if));

    assign a0_if.mar_addr  = x_addr;
    assign a0_if.bus       = x_data;
    assign a0_if.ram_read  = x0_rd;
    assign a0_if.ram_write = x0_wr;
    assign a3_if.mar_addr  = x_addr;
    assign a3_if.bus       = x_data;
    assign a3_if.ram_read  = x3_rd;
    assign a3_if.ram_write = x3_wr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every ready pulse and applies the access to the model.
    always @(negedge clk) begin
        exp_t e;
        logic exp_err;
        if (rst) begin
            check("rst_ram_out", m_if.ram_out, 32'd0);
            check("rst_ram_ready", m_if.ram_ready, 32'd0);
            check("rst_busy", m_if.busy, 32'd0);
            check("rst_addr_err", m_if.addr_err, 32'd0);
            mo       = 16'd0;
            mo_known = 1'b1;
        end else if (m_if.ram_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", m_if.ram_ready, 32'd0);
            end else begin
                e       = sb.pop_front();
                exp_err = (e.op == OP_ILL) || (e.addr[15:8] != 8'd0);
                check("ready_latency", cyc, e.ready_cyc);
                check("addr_err", m_if.addr_err, {31'd0, exp_err});
                if (e.op == OP_WR && !exp_err) begin
                    mm[e.addr[7:0]] = e.data;
                    mk[e.addr[7:0]] = 1'b1;
                end else if (e.op == OP_RD) begin
                    if (exp_err) begin
                        mo       = 16'd0;
                        mo_known = 1'b1;
                    end else begin
                        mo       = mm[e.addr[7:0]];
                        mo_known = mk[e.addr[7:0]];
                    end
                end
                if (mo_known) check("ram_out_at_ready", m_if.ram_out, mo);
            end
        end else begin
            check("err_without_ready", m_if.addr_err, 32'd0);
            if (mo_known) check("ram_out_hold", m_if.ram_out, mo);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_if.busy && n < 50) begin
            step();
            n++;
        end
        check("idle_timeout", m_if.busy, 32'd0);
    endtask

    task automatic do_req(input op_t op, input logic [15:0] addr, input logic [15:0] data);
        exp_t e;
        int   n = 0;
        wait_idle();
        e.op        = op;
        e.addr      = addr;
        e.data      = data;
        e.ready_cyc = cyc + 1 + ((op == OP_ILL) ? 0 : W_MAIN);
        sb.push_back(e);
        m_if.mar_addr  = addr;
        m_if.bus       = data;
        m_if.ram_read  = (op != OP_WR);
        m_if.ram_write = (op != OP_RD);
        step();
        // Scramble address/data while in flight; the captured copy must win.
        while (!m_if.ram_ready && n < 40) begin
            m_if.mar_addr = 16'($urandom);
            m_if.bus      = 16'($urandom);
            step();
            n++;
        end
        check("ready_timeout", m_if.ram_ready, 32'd1);
        m_if.ram_read  = 1'b0;
        m_if.ram_write = 1'b0;
        step();
    endtask

    task automatic aux_req(input logic is_wr, input logic [15:0] addr, input logic [15:0] data,
                           input logic [15:0] exp_out, input logic exp_err, input logic chk_out);
        int r0 = -1, r3 = -1, b0 = 0, b3 = 0;
        x_addr = addr;
        x_data = data;
        x0_rd  = !is_wr;
        x0_wr  = is_wr;
        x3_rd  = !is_wr;
        x3_wr  = is_wr;
        for (int n = 0; n < 12; n++) begin
            step();
            x_addr = 16'($urandom);
            x_data = 16'($urandom);
            if (a0_if.busy) b0++;
            if (a3_if.busy) b3++;
            if (a0_if.ram_ready && r0 < 0) begin
                r0 = n;
                x0_rd = 1'b0;
                x0_wr = 1'b0;
                check("w0_addr_err", a0_if.addr_err, {31'd0, exp_err});
                if (chk_out) check("w0_ram_out", a0_if.ram_out, exp_out);
            end
            if (a3_if.ram_ready && r3 < 0) begin
                r3 = n;
                x3_rd = 1'b0;
                x3_wr = 1'b0;
                check("w3_addr_err", a3_if.addr_err, {31'd0, exp_err});
                if (chk_out) check("w3_ram_out", a3_if.ram_out, exp_out);
            end
        end
        check("w0_latency", r0, 32'd0);
        check("w3_latency", r3, 32'd3);
        check("w0_busy_cycles", b0, 32'd1);
        check("w3_busy_cycles", b3, 32'd4);
        x0_rd = 1'b0; x0_wr = 1'b0; x3_rd = 1'b0; x3_wr = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        int   seen;
        int   r;
        logic [15:0] a;
        m_if.mar_addr = 16'd0; m_if.bus = 16'd0;
        m_if.ram_read = 1'b0;  m_if.ram_write = 1'b0;
        x_addr = 16'd0; x_data = 16'd0;
        x0_rd = 1'b0; x0_wr = 1'b0; x3_rd = 1'b0; x3_wr = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        aux_req(1'b1, 16'h0005, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
        aux_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        aux_req(1'b1, 16'h0105, 16'h1234, 16'h0000, 1'b1, 1'b0);
        aux_req(1'b0, 16'h0105, 16'h0000, 16'h0000, 1'b1, 1'b1);
        aux_req(1'b0, 16'h0005, 16'h0000, 16'hBEEF, 1'b0, 1'b1);

        do_req(OP_WR,  16'h0005, 16'hBEEF);
        do_req(OP_RD,  16'h0005, 16'h0000);
        do_req(OP_WR,  16'h0105, 16'h1234);
        do_req(OP_RD,  16'h0005, 16'h0000);
        do_req(OP_RD,  16'h0105, 16'h0000);
        do_req(OP_ILL, 16'h0005, 16'h7777);
        do_req(OP_RD,  16'h0005, 16'h0000);

        // Reset in the middle of a write: it must neither commit nor pulse ready.
        do_req(OP_WR, 16'h0010, 16'hA5A5);
        wait_idle();
        m_if.mar_addr  = 16'h0010;
        m_if.bus       = 16'h5A5A;
        m_if.ram_write = 1'b1;
        step();
        check("abort_busy_in_wait", m_if.busy, 32'd1);
        rst            = 1'b1;
        m_if.ram_write = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        do_req(OP_RD, 16'h0010, 16'h0000);

        // Held read request: accepted again in the IDLE cycle after DONE.
        wait_idle();
        e.op = OP_RD; e.addr = 16'h0005; e.data = 16'h0000;
        e.ready_cyc = cyc + 1 + W_MAIN;
        sb.push_back(e);
        e.ready_cyc = cyc + 1 + W_MAIN + W_MAIN + 2;
        sb.push_back(e);
        m_if.mar_addr = 16'h0005;
        m_if.ram_read = 1'b1;
        n = 0;
        seen = 0;
        while (seen < 2 && n < 30) begin
            step();
            n++;
            if (m_if.ram_ready) seen++;
        end
        check("b2b_two_pulses", seen, 32'd2);
        m_if.ram_read = 1'b0;
        step();

        for (int i = 0; i < 16; i++) do_req(OP_WR, 16'(i), 16'($urandom));
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 7);
            a = {8'd0, 8'($urandom_range(0, 15))};
            if ($urandom_range(0, 5) == 0) a[15:8] = 8'($urandom_range(1, 255));
            do_req((r == 0) ? OP_ILL : (r < 4) ? OP_WR : OP_RD, a, 16'($urandom));
        end

        repeat (5) step();
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
